// File: rtl/seq_alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the sequential ALU.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;
    localparam int NUM_FLAGS  = 4;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // product is the accumulator after this cycle's step; it is final when done is high.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Valid/ready sequential ALU: single-cycle logic ops, iterative multiply, registered flags.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             neg_flag,
    output logic             ovf_flag
);

    localparam int SW = $clog2(WIDTH);

    state_t                 state, state_nxt;
    opcode_t                op;
    logic                   accept, is_mul;
    logic                   mul_done;
    logic [2*WIDTH-1:0]     mul_product;
    logic [WIDTH:0]         sum, shl;
    logic [WIDTH-1:0]       res, ld_res;
    logic                   carry, ovf, ld_carry, ld_ovf, load;
    logic [NUM_FLAGS-1:0]   flags, flags_nxt;

    assign op     = opcode_t'(opcode);
    assign is_mul = (op == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        sum   = '0;
        shl   = '0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, A} + {1'b0, B};
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sum   = {1'b0, A} - {1'b0, B};
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_NOT: res = ~A;
            OP_XOR: res = A ^ B;
            OP_SHL: begin
                // The extra top bit catches the last bit shifted out (zero for a zero shift).
                shl   = {1'b0, A} << B[SW-1:0];
                res   = shl[WIDTH-1:0];
                carry = shl[WIDTH];
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
        out_valid = (state == ST_DONE);
        accept    = in_valid && in_ready;
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = is_mul ? ST_BUSY : ST_DONE;
            ST_BUSY: if (mul_done) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = accept ? (is_mul ? ST_BUSY : ST_DONE) : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        ld_res   = res;
        ld_carry = carry;
        ld_ovf   = ovf;
        if (accept && !is_mul) begin
            load = 1'b1;
        end else if ((state == ST_BUSY) && mul_done) begin
            load     = 1'b1;
            ld_res   = mul_product[WIDTH-1:0];
            ld_carry = |mul_product[2*WIDTH-1:WIDTH];
            ld_ovf   = 1'b0;
        end
        flags_nxt             = '0;
        flags_nxt[FLAG_ZERO]  = (ld_res == '0);
        flags_nxt[FLAG_CARRY] = ld_carry;
        flags_nxt[FLAG_NEG]   = ld_res[WIDTH-1];
        flags_nxt[FLAG_OVF]   = ld_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            out   <= '0;
            flags <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out   <= ld_res;
                flags <= flags_nxt;
            end
        end
    end

    assign zero_flag  = flags[FLAG_ZERO];
    assign carry_flag = flags[FLAG_CARRY];
    assign neg_flag   = flags[FLAG_NEG];
    assign ovf_flag   = flags[FLAG_OVF];

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=8 and WIDTH=16.
module tb_seq_alu;

    typedef struct {
        logic [63:0] out;
        logic [3:0]  flags;   // {ovf, neg, carry, zero}
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    logic        v8 = 0, ordy8 = 1, r8, ov8, z8, c8, n8, f8;
    logic [7:0]  a8 = 0, b8 = 0, o8;
    logic [2:0]  op8 = 0;
    logic        v16 = 0, ordy16 = 1, r16, ov16, z16, c16, n16, f16;
    logic [15:0] a16 = 0, b16 = 0, o16;
    logic [2:0]  op16 = 0;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .A(a8), .B(b8),
        .opcode(op8), .out_valid(ov8), .out_ready(ordy8), .out(o8),
        .zero_flag(z8), .carry_flag(c8), .neg_flag(n8), .ovf_flag(f8));

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .A(a16), .B(b16),
        .opcode(op16), .out_valid(ov16), .out_ready(ordy16), .out(o16),
        .zero_flag(z16), .carry_flag(c16), .neg_flag(n16), .ovf_flag(f16));

    int checks = 0;
    int errors = 0;
    res_t sb8[$];
    res_t sb16[$];
    res_t exp;

    function automatic res_t model(input int w, input logic [2:0] op, input logic [63:0] a_in, input logic [63:0] b_in);
        res_t        rr;
        logic [127:0] full;
        logic [63:0] mask, a, b, r;
        logic        c, v;
        int          sh;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        c = 0; v = 0; r = 0; full = 0;
        case (op)
            3'd0: begin
                full = {64'b0, a} + {64'b0, b};
                r = full[63:0] & mask;
                c = full[w];
                v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd1: begin
                r = (a - b) & mask;
                c = (a < b);
                v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~a & mask;
            3'd5: r = a ^ b;
            3'd6: begin
                sh = int'(b[5:0]) & (w - 1);
                full = {64'b0, a} << sh;
                r = full[63:0] & mask;
                c = (sh == 0) ? 1'b0 : a[w-sh];
            end
            default: begin
                full = {64'b0, a} * {64'b0, b};
                r = full[63:0] & mask;
                c = ((full >> w) != 0);
            end
        endcase
        rr.out = r;
        rr.flags = {v, r[w-1], c, (r == 0)};
        return rr;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents an op on dut8 until accepted; acc is the cycle in which the handshake happened.
    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int acc);
        v8 = 1; op8 = op; a8 = a; b8 = b;
        #1;
        for (int i = 0; i < 40 && !r8; i++) tick;
        checks++;
        if (r8 !== 1'b1) begin
            errors++;
            $display("FAIL issue8_timeout: in_ready=%b required 1", r8);
        end
        acc = cycle;
        tick;
        v8 = 0;
    endtask

    task automatic wait_valid8(output int vc, output bit rdy_seen);
        rdy_seen = 0;
        for (int i = 0; i < 40 && !ov8; i++) begin
            if (r8) rdy_seen = 1;
            tick;
        end
        vc = cycle;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({ov8, o8, f8, n8, c8, z8, r8} !== {1'b0, 8'h00, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset8: valid=%b out=%h flags=%b ready=%b required 0 00 0000 1", ov8, o8, {f8, n8, c8, z8}, r8);
        end
        checks++;
        if ({ov16, o16, f16, n16, c16, z16, r16} !== {1'b0, 16'h0000, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset16: valid=%b out=%h flags=%b ready=%b required 0 0000 0000 1", ov16, o16, {f16, n16, c16, z16}, r16);
        end
        @(negedge clk) rst_n = 1;
        tick;
    endtask

    task automatic test_add;
        int acc;
        ordy8 = 1;
        sb8.push_back('{out: 64'h00, flags: 4'b0011});
        issue8(3'd0, 8'hFF, 8'h01, acc);
        checks++;
        if (!ov8 || (cycle - acc) != 1) begin
            errors++;
            $display("FAIL add_latency: valid=%b latency=%0d required 1 1", ov8, cycle - acc);
        end
        exp = sb8.pop_front();
        checks++;
        if (o8 !== exp.out[7:0] || {f8, n8, c8, z8} !== exp.flags) begin
            errors++;
            $display("FAIL add_ff_01: out=%h flags=%b required %h %b", o8, {f8, n8, c8, z8}, exp.out[7:0], exp.flags);
        end
        tick;
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL add_consumed: valid=%b required 0", ov8);
        end
    endtask

    task automatic test_sub;
        int acc;
        logic [7:0] av [2] = '{8'h80, 8'h03};
        logic [7:0] bv [2] = '{8'h01, 8'h0A};
        res_t ev [2] = '{'{out: 64'h7F, flags: 4'b1000}, '{out: 64'hF9, flags: 4'b0110}};
        ordy8 = 1;
        for (int i = 0; i < 2; i++) begin
            sb8.push_back(ev[i]);
            issue8(3'd1, av[i], bv[i], acc);
            exp = sb8.pop_front();
            checks++;
            if (!ov8 || o8 !== exp.out[7:0] || {f8, n8, c8, z8} !== exp.flags) begin
                errors++;
                $display("FAIL sub_%0d: valid=%b out=%h flags=%b required 1 %h %b", i, ov8, o8, {f8, n8, c8, z8}, exp.out[7:0], exp.flags);
            end
            tick;
        end
    endtask

    task automatic test_mul;
        int acc, vc;
        bit rdy_seen;
        ordy8 = 1;
        sb8.push_back('{out: 64'h10, flags: 4'b0010});
        issue8(3'd7, 8'h10, 8'h11, acc);
        wait_valid8(vc, rdy_seen);
        checks++;
        if (!ov8 || (vc - acc) != 9 || rdy_seen) begin
            errors++;
            $display("FAIL mul8_timing: valid=%b latency=%0d ready_in_busy=%b required 1 9 0", ov8, vc - acc, rdy_seen);
        end
        exp = sb8.pop_front();
        checks++;
        if (o8 !== exp.out[7:0] || {f8, n8, c8, z8} !== exp.flags) begin
            errors++;
            $display("FAIL mul8_10x11: out=%h flags=%b required %h %b", o8, {f8, n8, c8, z8}, exp.out[7:0], exp.flags);
        end
        tick;
    endtask

    task automatic test_backpressure;
        int acc;
        ordy8 = 0;
        sb8.push_back('{out: 64'hA5, flags: 4'b0100});
        issue8(3'd5, 8'hAA, 8'h0F, acc);
        v8 = 1; op8 = 3'd0; a8 = 8'h01; b8 = 8'h02;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({ov8, o8, f8, n8, c8, z8, r8} !== {1'b1, 8'hA5, 4'b0100, 1'b0}) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b out=%h flags=%b ready=%b required 1 a5 0100 0", i, ov8, o8, {f8, n8, c8, z8}, r8);
            end
            tick;
        end
        ordy8 = 1;
        #1;
        exp = sb8.pop_front();
        checks++;
        if (!r8 || o8 !== exp.out[7:0] || {f8, n8, c8, z8} !== exp.flags) begin
            errors++;
            $display("FAIL bp_release: ready=%b out=%h flags=%b required 1 %h %b", r8, o8, {f8, n8, c8, z8}, exp.out[7:0], exp.flags);
        end
        sb8.push_back('{out: 64'h03, flags: 4'b0000});
        tick;
        v8 = 0;
        exp = sb8.pop_front();
        checks++;
        if (!ov8 || o8 !== exp.out[7:0] || {f8, n8, c8, z8} !== exp.flags) begin
            errors++;
            $display("FAIL bp_second: valid=%b out=%h flags=%b required 1 %h %b", ov8, o8, {f8, n8, c8, z8}, exp.out[7:0], exp.flags);
        end
        tick;
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: valid=%b required 0", ov8);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] ops [4] = '{3'd2, 3'd3, 3'd4, 3'd6};
        logic [7:0] av  [4] = '{8'hF0, 8'hF0, 8'h55, 8'h81};
        logic [7:0] bv  [4] = '{8'h3C, 8'h0C, 8'h00, 8'h01};
        res_t ev [4] = '{'{out: 64'h30, flags: 4'b0000}, '{out: 64'hFC, flags: 4'b0100},
                         '{out: 64'hAA, flags: 4'b0100}, '{out: 64'h02, flags: 4'b0010}};
        ordy8 = 1;
        v8 = 1;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                exp = sb8.pop_front();
                checks++;
                if (!ov8 || o8 !== exp.out[7:0] || {f8, n8, c8, z8} !== exp.flags) begin
                    errors++;
                    $display("FAIL stream_%0d: valid=%b out=%h flags=%b required 1 %h %b", i - 1, ov8, o8, {f8, n8, c8, z8}, exp.out[7:0], exp.flags);
                end
            end
            if (i < 4) begin
                op8 = ops[i]; a8 = av[i]; b8 = bv[i];
                #1;
                checks++;
                if (r8 !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready_%0d: ready=%b required 1", i, r8);
                end
                sb8.push_back(ev[i]);
            end else begin
                v8 = 0;
            end
            tick;
        end
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: valid=%b required 0", ov8);
        end
    endtask

    task automatic test_random;
        int acc, vc;
        bit rdy_seen;
        logic [2:0] op;
        logic [7:0] a, b;
        ordy8 = 1;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            if (i == 0) begin op = 3'd6; a = 8'h03; b = 8'h0F; end
            if (i == 1) begin op = 3'd6; a = 8'hC3; b = 8'h08; end
            if (i == 2) begin op = 3'd0; a = 8'h7F; b = 8'h01; end
            sb8.push_back(model(8, op, {56'b0, a}, {56'b0, b}));
            issue8(op, a, b, acc);
            wait_valid8(vc, rdy_seen);
            exp = sb8.pop_front();
            checks++;
            if (!ov8 || o8 !== exp.out[7:0] || {f8, n8, c8, z8} !== exp.flags) begin
                errors++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h: out=%h flags=%b required %h %b", i, op, a, b, o8, {f8, n8, c8, z8}, exp.out[7:0], exp.flags);
            end
            tick;
        end
    endtask

    task automatic test_reset_mid_mul;
        int acc;
        ordy8 = 1;
        sb8.push_back('{out: 64'h80, flags: 4'b1100});
        issue8(3'd0, 8'h7F, 8'h01, acc);
        exp = sb8.pop_front();
        checks++;
        if (!ov8 || o8 !== exp.out[7:0] || {f8, n8, c8, z8} !== exp.flags) begin
            errors++;
            $display("FAIL pre_reset_add: valid=%b out=%h flags=%b required 1 %h %b", ov8, o8, {f8, n8, c8, z8}, exp.out[7:0], exp.flags);
        end
        tick;
        issue8(3'd7, 8'hFF, 8'hFF, acc);
        tick; tick; tick;
        checks++;
        if (r8 !== 1'b0 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL busy_c4: ready=%b valid=%b required 0 0", r8, ov8);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({ov8, o8, f8, n8, c8, z8, r8} !== {1'b0, 8'h00, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL mid_mul_reset: valid=%b out=%h flags=%b ready=%b required 0 00 0000 1", ov8, o8, {f8, n8, c8, z8}, r8);
        end
        tick; tick;
        @(negedge clk);
        rst_n = 1;
        v8 = 1; op8 = 3'd0; a8 = 8'h05; b8 = 8'h03;
        sb8.push_back('{out: 64'h08, flags: 4'b0000});
        tick;
        v8 = 0;
        exp = sb8.pop_front();
        checks++;
        if (!ov8 || o8 !== exp.out[7:0] || {f8, n8, c8, z8} !== exp.flags) begin
            errors++;
            $display("FAIL post_reset_add: valid=%b out=%h flags=%b required 1 %h %b", ov8, o8, {f8, n8, c8, z8}, exp.out[7:0], exp.flags);
        end
        for (int i = 0; i < 12; i++) begin
            tick;
            checks++;
            if (ov8 !== 1'b0) begin
                errors++;
                $display("FAIL aborted_mul_output_%0d: valid=%b required 0", i, ov8);
            end
        end
    endtask

    task automatic test_mul16;
        int acc, vc;
        bit rdy_seen;
        ordy16 = 1;
        v16 = 1; op16 = 3'd7; a16 = 16'h1234; b16 = 16'h0100;
        sb16.push_back('{out: 64'h3400, flags: 4'b0010});
        #1;
        for (int i = 0; i < 40 && !r16; i++) tick;
        acc = cycle;
        tick;
        v16 = 0;
        a16 = 16'hFFFF; b16 = 16'hFFFF;
        rdy_seen = 0;
        for (int i = 0; i < 60 && !ov16; i++) begin
            if (r16) rdy_seen = 1;
            tick;
        end
        vc = cycle;
        checks++;
        if (!ov16 || (vc - acc) != 17 || rdy_seen) begin
            errors++;
            $display("FAIL mul16_timing: valid=%b latency=%0d ready_in_busy=%b required 1 17 0", ov16, vc - acc, rdy_seen);
        end
        exp = sb16.pop_front();
        checks++;
        if (o16 !== exp.out[15:0] || {f16, n16, c16, z16} !== exp.flags) begin
            errors++;
            $display("FAIL mul16_1234x0100: out=%h flags=%b required %h %b", o16, {f16, n16, c16, z16}, exp.out[15:0], exp.flags);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_mul;
        test_backpressure;
        test_back_to_back;
        test_random;
        test_reset_mid_mul;
        test_mul16;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal values are powers of two, 4 to 64.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand/opcode presented.
REQ-005 SHALL have port in_ready  output  1  block accepts operation this cycle.
REQ-006 SHALL have port A  input  WIDTH  operand A.
REQ-007 SHALL have port B  input  WIDTH  operand B.
REQ-008 SHALL have port opcode  input  3  operation select.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out  output  WIDTH  registered result.
REQ-012 SHALL have port zero_flag, carry_flag, neg_flag, ovf_flag  output  1 each  registered status flags.

Function
REQ-013 SHALL decode opcode: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 NOT A, 101 XOR, 110 SHL (A shifted left by B[log2(WIDTH)-1:0]), 111 MUL (low WIDTH bits of unsigned A*B).
REQ-014 SHALL accept an operation on a cycle with in_valid and in_ready both high; A, B, opcode are captured then, and later input changes have no effect on that operation.
REQ-015 SHALL drive in_ready = (state IDLE) or (state DONE and out_ready).
REQ-016 SHALL use FSM states IDLE, BUSY, DONE: IDLE->DONE on accepted non-MUL; IDLE->BUSY on accepted MUL; BUSY->DONE after WIDTH iteration cycles; DONE->IDLE on out_ready without new accept; DONE->DONE or DONE->BUSY on out_ready with simultaneous accept.
REQ-017 SHALL assert out_valid exactly while in DONE; non-MUL latency 1 cycle (out_valid the cycle after accept), MUL latency WIDTH+1 cycles.
REQ-018 SHALL hold out and all flags stable while out_valid is high and out_ready is low.
REQ-019 SHALL compute MUL iteratively (one shift-add step per BUSY cycle), not with a single-cycle multiplier.
REQ-020 SHALL set zero_flag = (out == 0) for every opcode.
REQ-021 SHALL set neg_flag = out[WIDTH-1] for every opcode.
REQ-022 SHALL set carry_flag: ADD carry-out; SUB borrow (1 when A<B unsigned); SHL last bit shifted out (0 when shift amount 0); MUL 1 when upper WIDTH product bits nonzero; 0 otherwise.
REQ-023 SHALL set ovf_flag to two's-complement signed overflow for ADD and SUB, 0 for all other opcodes.
REQ-024 SHALL ignore in_valid while in BUSY or in DONE without out_ready (in_ready low); no operation is lost or duplicated.
REQ-025 SHALL sustain one non-MUL result per cycle when in_valid and out_ready are held high.

Reset
REQ-026 SHALL, on rst_n low, immediately force state IDLE, out_valid 0, out 0, all flags 0, MUL iteration counter and partial product 0; in_ready reads 1 after reset.
REQ-027 SHALL abort any in-progress MUL or pending unconsumed result on reset with no output produced for it.
REQ-028 SHALL resume normal acceptance on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 SHALL place the opcode enumeration, FSM state enumeration and flag-vector index constants in shared package seq_alu_pkg.
REQ-030 SHALL implement the iterative multiplier as sub-module seq_alu_mul (start, operands, done, 2*WIDTH product), parametrised by WIDTH.

Verification (WIDTH=8 unless stated)
REQ-031 SHALL cover ADD 8'hFF + 8'h01 -> out 8'h00, zero 1, carry 1, ovf 0, out_valid one cycle after accept.
REQ-032 SHALL cover SUB 8'h80 - 8'h01 -> out 8'h7F, ovf 1, carry 0, neg 0; SUB 8'h03 - 8'h0A -> out 8'hF9, carry 1, neg 1.
REQ-033 SHALL cover MUL 8'h10 * 8'h11 -> out 8'h10, carry 1, out_valid exactly 9 cycles after accept, in_ready low throughout BUSY.
REQ-034 SHALL cover back-pressure: out_ready low 5 cycles after XOR 8'hAA^8'h0F -> out 8'hA5 held stable, in_ready low, second in_valid not accepted until out_ready high.
REQ-035 SHALL cover streaming: 4 back-to-back ops (AND, OR, NOT, SHL 8'h81 by 1 -> 8'h02, carry 1) with out_ready high -> 4 consecutive out_valid cycles in order.
REQ-036 SHALL cover rst_n pulsed low mid-MUL (cycle 4 of BUSY) -> out_valid 0, out 0, flags 0 immediately; next accepted ADD 8'h05+8'h03 -> 8'h08; repeat MUL case with WIDTH=16.
